piso_serializer: RTL and testbench

- Parametrised parallel-in/serial-out shifter. Loads a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per bit-rate enable.
- Supports LSB- or MSB-first order, programmable idle line level and back-to-back frames.
- Sits between word-level datapath logic and a serial line driver or bit-level encoder.

---
 rtl/piso_pkg.sv | 22 ++
 rtl/piso_serializer.sv | 140 ++++++++++++++
 tb/tb_piso_serializer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// piso_pkg
// Shared definitions for the parallel-in/serial-out serializer.
//   state_t   : FSM encoding (PARITY is only reachable when PISO_PARITY_EN is defined)
//   cnt_w()   : width of the bit counter needed to count 0..width
//   MAX_WIDTH : largest supported word width
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 64;

    // The counter has to be able to hold the value WIDTH-1 for the terminal
    // compare; sizing it for WIDTH keeps the expression simple and safe.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// piso_serializer
// Loads a WIDTH-bit word through a valid/ready handshake and shifts it out
// one bit per shift_en strobe, LSB- or MSB-first, with back-to-back frames.
// Optional even-parity trailer bit when the macro PISO_PARITY_EN is defined.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : in_data holds a word to load
//   in_ready  : a word can be accepted this cycle
//   in_data   : parallel word, sampled on the handshake edge
//   shift_en  : bit-rate strobe, advances one bit while a frame is active
//   ser_out   : serial data (IDLE_LEVEL when no frame is active)
//   ser_valid : ser_out carries frame data
//   busy      : a frame is in progress
//   done      : the final bit of the frame is consumed this cycle
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = 7,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_w(WIDTH);

    // Reject unsupported widths at elaboration time.
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("piso_serializer: WIDTH=%0d outside legal range 2..%0d", WIDTH, MAX_WIDTH);
    end

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last_data;
    logic             accept;

`ifdef PISO_PARITY_EN
    logic parity;
`endif

    // The last data bit is being consumed on this edge.
    assign last_data = (state == SHIFT) && (cnt == CW'(WIDTH - 1)) && shift_en;

    // The end of the frame moves to the parity strobe when the trailer is enabled;
    // in_ready follows it so a new word can be taken on that same edge.
`ifdef PISO_PARITY_EN
    assign done = (state == PARITY) && shift_en;
`else
    assign done = last_data;
`endif

    assign in_ready  = (state == IDLE) | done;
    assign accept    = in_valid & in_ready;
    assign busy      = (state != IDLE);
    assign ser_valid = (state != IDLE);

    // Output bit selection: the register always shifts toward the output end,
    // so the current bit is a fixed position of sreg.
    always_comb begin
        ser_out = IDLE_LEVEL;
        case (state)
            SHIFT:   ser_out = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
`ifdef PISO_PARITY_EN
            PARITY:  ser_out = parity;
`endif
            default: ser_out = IDLE_LEVEL;
        endcase
    end

    // FSM, shift register and bit counter. Loading a word always restarts the
    // counter, whether from IDLE or on the done edge of a previous frame, which
    // is what gives gap-free back-to-back frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            if (accept) begin
                state <= SHIFT;
                sreg  <= in_data;
                cnt   <= '0;
`ifdef PISO_PARITY_EN
                parity <= ^in_data;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    SHIFT: begin
                        if (shift_en) begin
                            if (LSB_FIRST) begin
                                sreg <= {1'b0, sreg[WIDTH-1:1]};
                            end else begin
                                sreg <= {sreg[WIDTH-2:0], 1'b0};
                            end
                            if (last_data) begin
`ifdef PISO_PARITY_EN
                                state <= PARITY;
`else
                                state <= IDLE;
`endif
                                cnt <= '0;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                    end
`ifdef PISO_PARITY_EN
                    PARITY: begin
                        if (shift_en) begin
                            state <= IDLE;
                        end
                    end
`endif
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
// Directed bench for piso_serializer. Two instances share all inputs: one
// LSB-first, one MSB-first, so each vector checks both bit orders.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_piso_serializer;

    localparam int W = 7;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         shift_en;

    logic in_ready, ser_out, ser_valid, busy, done;
    logic m_in_ready, m_ser_out, m_ser_valid, m_busy, m_done;

    int n_checks;
    int n_fail;

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .shift_en  (shift_en),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .in_data   (in_data),
        .shift_en  (shift_en),
        .ser_out   (m_ser_out),
        .ser_valid (m_ser_valid),
        .busy      (m_busy),
        .done      (m_done)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         in_valid;
        logic [W-1:0] in_data;
        logic         shift_en;
        logic         e_ser;
        logic         e_msb;
        logic         e_valid;
        logic         e_ready;
        logic         e_done;
    } vec_t;

    vec_t vecs[$];

    // Drive one cycle's inputs on the falling edge, then settle.
    task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d, input logic se);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_data  = d;
        shift_en = se;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Full output check of both instances for one cycle.
    task automatic checkAll(input string tag, input logic e_ser, input logic e_msb,
                            input logic e_valid, input logic e_ready, input logic e_done);
        checkOutput({tag, " ser_out"},     ser_out,     e_ser);
        checkOutput({tag, " msb ser_out"}, m_ser_out,   e_msb);
        checkOutput({tag, " ser_valid"},   ser_valid,   e_valid);
        checkOutput({tag, " busy"},        busy,        e_valid);
        checkOutput({tag, " in_ready"},    in_ready,    e_ready);
        checkOutput({tag, " done"},        done,        e_done);
        checkOutput({tag, " msb done"},    m_done,      e_done);
    endtask

    logic [W-1:0] word;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        shift_en = 1'b0;

        // Reset state.
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifndef PISO_PARITY_EN
        // Vector table: 7'h59 at full rate, then back-to-back 7'h01 / 7'h40.
        // Columns: rst, in_valid, in_data, shift_en | ser, msb_ser, valid, ready, done
        vecs.push_back('{1'b0, 1'b1, 7'h59, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        // Back-to-back frames with in_valid held high.
        vecs.push_back('{1'b0, 1'b1, 7'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 7'h40, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 7'h40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].in_valid, vecs[i].in_data, vecs[i].shift_en);
            checkAll($sformatf("vec%0d", i), vecs[i].e_ser, vecs[i].e_msb,
                     vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_done);
        end

        // Bit-rate gating: 7'h7F with a strobe every 4th cycle.
        applyStimulus(1'b0, 1'b1, 7'h7F, 1'b0);
        for (int k = 0; k < 28; k++) begin
            applyStimulus(1'b0, 1'b0, '0, (k % 4 == 3));
            checkAll($sformatf("gate%0d", k), 1'b1, 1'b1, 1'b1, (k == 27), (k == 27));
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkAll("gate_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`else
        // Parity trailer: 7'h59 has even weight (parity 0), 7'h58 odd (parity 1).
        for (int f = 0; f < 2; f++) begin
            word = (f == 0) ? 7'h59 : 7'h58;
            applyStimulus(1'b0, 1'b1, word, 1'b1);
            for (int b = 0; b < W; b++) begin
                applyStimulus(1'b0, 1'b0, '0, 1'b1);
                checkAll($sformatf("par%0d_bit%0d", f, b), word[b], word[W-1-b], 1'b1, 1'b0, 1'b0);
            end
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            checkAll($sformatf("par%0d_trailer", f), (f == 1), (f == 1), 1'b1, 1'b1, 1'b1);
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            checkAll($sformatf("par%0d_idle", f), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
`endif

        // Reset in mid-frame: three bits of 7'h55, then abort.
        word = 7'h55;
        applyStimulus(1'b0, 1'b1, word, 1'b1);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            checkAll($sformatf("abort_bit%0d", b), word[b], word[W-1-b], 1'b1, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("abort rst-cycle done", done, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkAll("abort_after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // A fresh word after the abort starts from bit 0.
        word = 7'h2A;
        applyStimulus(1'b0, 1'b1, word, 1'b1);
        for (int b = 0; b < W; b++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
`ifndef PISO_PARITY_EN
            checkAll($sformatf("reload_bit%0d", b), word[b], word[W-1-b], 1'b1, (b == W-1), (b == W-1));
`else
            checkAll($sformatf("reload_bit%0d", b), word[b], word[W-1-b], 1'b1, 1'b0, 1'b0);
`endif
        end
`ifdef PISO_PARITY_EN
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkAll("reload_trailer", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
`endif
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkAll("reload_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
